// File: rtl/spart_rx.sv
// spart_rx: SPART UART receive stage.
// The block samples rxd at 16x the bit rate and deframes 8N1 characters, LSB first.
// Each good byte appears on rx_data together with a one-cycle rda strobe.
// Define SPART_RX_PARITY_EN to build 8E1 framing, which adds the parity_err output.
module spart_rx #(
    parameter int unsigned DIVISOR = 27,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
`ifdef SPART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
`ifdef SPART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd3;
`endif
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIVISOR - 1);

`ifdef SPART_RX_PARITY_EN
    // Even parity over the data byte and the received parity bit is good when it is zero.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction
`endif

    logic             rxd_meta_r;
    logic             rxs_r;
    logic [CNT_W-1:0] div_cnt_r;
    logic             tick_s;
    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [3:0]       os_cnt_r;
    logic [3:0]       os_cnt_nxt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic             load_s;
    logic             ferr_set_s;
    logic [7:0]       rx_data_r;
    logic             rda_r;
    logic             ferr_r;
    logic             busy_r;
`ifdef SPART_RX_PARITY_EN
    logic             par_bit_r;
    logic             par_bit_nxt_s;
    logic             perr_set_s;
    logic             perr_r;
`endif

    assign tick_s = (div_cnt_r == DIV_LAST);

    // Two-flop synchroniser for the asynchronous serial line. It idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_r <= 1'b1;
            rxs_r      <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxs_r      <= rxd_meta_r;
        end
    end

    // Free-running divider that produces one 16x oversample tick every DIVISOR clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            div_cnt_r <= {CNT_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic: moves through the frame on ticks and samples the line at mid-bit.
    always_comb begin
        state_nxt_s   = state_r;
        os_cnt_nxt_s  = os_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        load_s        = 1'b0;
        ferr_set_s    = 1'b0;
`ifdef SPART_RX_PARITY_EN
        par_bit_nxt_s = par_bit_r;
        perr_set_s    = 1'b0;
`endif
        if (tick_s) begin
            case (state_r)
                IDLE: begin
                    if (!rxs_r) begin
                        os_cnt_nxt_s = 4'd0;
                        state_nxt_s  = START;
                    end else begin
                        state_nxt_s  = IDLE;
                    end
                end
                START: begin
                    if (os_cnt_r == 4'd7) begin
                        if (rxs_r) begin
                            state_nxt_s   = IDLE;
                        end else begin
                            os_cnt_nxt_s  = 4'd0;
                            bit_idx_nxt_s = 3'd0;
                            state_nxt_s   = DATA;
                        end
                    end else begin
                        os_cnt_nxt_s = os_cnt_r + 4'd1;
                    end
                end
                DATA: begin
                    os_cnt_nxt_s = os_cnt_r + 4'd1;
                    if (os_cnt_r == 4'd15) begin
                        shift_nxt_s[bit_idx_r] = rxs_r;
                        bit_idx_nxt_s          = bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef SPART_RX_PARITY_EN
                            state_nxt_s = PARITY;
`else
                            state_nxt_s = STOP;
`endif
                        end else begin
                            state_nxt_s = DATA;
                        end
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
`ifdef SPART_RX_PARITY_EN
                PARITY: begin
                    os_cnt_nxt_s = os_cnt_r + 4'd1;
                    if (os_cnt_r == 4'd15) begin
                        par_bit_nxt_s = rxs_r;
                        state_nxt_s   = STOP;
                    end else begin
                        state_nxt_s   = PARITY;
                    end
                end
`endif
                STOP: begin
                    os_cnt_nxt_s = os_cnt_r + 4'd1;
                    if (os_cnt_r == 4'd15) begin
                        if (rxs_r) begin
`ifdef SPART_RX_PARITY_EN
                            if (parity_bad(shift_r, par_bit_r)) begin
                                perr_set_s = 1'b1;
                            end else begin
                                load_s     = 1'b1;
                            end
`else
                            load_s      = 1'b1;
`endif
                            state_nxt_s = IDLE;
                        end else begin
                            ferr_set_s  = 1'b1;
                            state_nxt_s = WAIT_HIGH;
                        end
                    end else begin
                        state_nxt_s = STOP;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT_HIGH;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state, oversample counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            os_cnt_r  <= 4'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef SPART_RX_PARITY_EN
            par_bit_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            os_cnt_r  <= os_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
`ifdef SPART_RX_PARITY_EN
            par_bit_r <= par_bit_nxt_s;
`endif
        end
    end

    // Registered outputs: byte hold register, one-cycle strobes and the busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_r <= 8'h00;
            rda_r     <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            perr_r    <= 1'b0;
`endif
        end else begin
            if (load_s) begin
                rx_data_r <= shift_r;
            end else begin
                rx_data_r <= rx_data_r;
            end
            rda_r  <= load_s;
            ferr_r <= ferr_set_s;
            busy_r <= (state_nxt_s != IDLE);
`ifdef SPART_RX_PARITY_EN
            perr_r <= perr_set_s;
`endif
        end
    end

    assign rx_data     = rx_data_r;
    assign rda         = rda_r;
    assign framing_err = ferr_r;
    assign rx_busy     = busy_r;
`ifdef SPART_RX_PARITY_EN
    assign parity_err  = perr_r;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: randomized self-checking bench for spart_rx, built with DIVISOR=4 (64 clk per bit).
// An expected-event queue predicts each rda or error pulse, its byte, and the time window in which it must occur.
module tb_spart_rx;

    localparam int DIV     = 4;
    localparam int BIT_CLK = 16 * DIV;
`ifdef SPART_RX_PARITY_EN
    localparam int  NBITS  = 11;
    localparam bit  PAR_EN = 1'b1;
`else
    localparam int  NBITS  = 10;
    localparam bit  PAR_EN = 1'b0;
`endif
    localparam int K_RDA  = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       rx_busy;
    logic       perr;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     earliest;
        longint     latest;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    longint      cyc      = 0;
    logic [7:0]  model_data = 8'h00;
    int          rda_cnt  = 0;
    int          ferr_cnt = 0;
    int          perr_cnt = 0;

    spart_rx #(.DIVISOR(DIV), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
`ifdef SPART_RX_PARITY_EN
        .parity_err  (perr),
`endif
        .rx_busy     (rx_busy)
    );

`ifndef SPART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
        end
    endfunction

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        tick_clk(n);
    endtask

    // Sends one frame; a bad stop holds the line low for hold_bits bit times.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_flip,
                              input int hold_bits);
        exp_t e;
        e.data     = d;
        e.kind     = !stop_ok ? K_FERR : ((PAR_EN && par_flip) ? K_PERR : K_RDA);
        e.earliest = cyc + longint'((NBITS - 1) * BIT_CLK);
        e.latest   = cyc + longint'(NBITS * BIT_CLK);
        exp_q.push_back(e);
        rxd = 1'b0;
        tick_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick_clk(BIT_CLK / 2);
            chk("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
            tick_clk(BIT_CLK / 2);
        end
        if (PAR_EN) begin
            rxd = (^d) ^ par_flip;
            tick_clk(BIT_CLK);
        end
        if (stop_ok) begin
            rxd = 1'b1;
            tick_clk(BIT_CLK);
        end else begin
            rxd = 1'b0;
            tick_clk(BIT_CLK * hold_bits);
            rxd = 1'b1;
        end
    endtask

    task automatic glitch(input int len);
        rxd = 1'b0;
        tick_clk(len);
        rxd = 1'b1;
    endtask

    // Compare process: checks every output on every cycle against the event queue and the held byte.
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
                chk("reset_rda", {31'd0, rda}, 32'd0);
                chk("reset_ferr", {31'd0, framing_err}, 32'd0);
                chk("reset_busy", {31'd0, rx_busy}, 32'd0);
                model_data = 8'h00;
            end else begin
                chk("pulse_exclusive", {29'd0, rda, framing_err, perr} & 32'h7,
                    (rda ? 32'h4 : 32'h0) | (framing_err ? 32'h2 : 32'h0) | (perr ? 32'h1 : 32'h0));
                chk("pulse_onehot", {31'd0, (32'(rda) + 32'(framing_err) + 32'(perr)) > 32'd1}, 32'd0);
                if (rda || framing_err || perr) begin
                    kind = rda ? K_RDA : (framing_err ? K_FERR : K_PERR);
                    if (rda) rda_cnt++;
                    if (framing_err) ferr_cnt++;
                    if (perr) perr_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 32'(kind), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", 32'(kind), 32'(e.kind));
                        chk("event_not_early", {31'd0, cyc >= e.earliest}, 32'd1);
                        if (kind == K_RDA) begin
                            chk("rx_data_on_rda", {24'd0, rx_data}, {24'd0, e.data});
                            model_data = e.data;
                        end else begin
                            chk("rx_data_held_err", {24'd0, rx_data}, {24'd0, model_data});
                        end
                    end
                end else begin
                    chk("rx_data_held", {24'd0, rx_data}, {24'd0, model_data});
                    if (exp_q.size() > 0 && cyc > exp_q[0].latest) begin
                        e = exp_q.pop_front();
                        chk("event_timeout", 32'(cyc - e.latest), 32'd0);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, f0, p0;
        logic [7:0] d;
        logic bad, flip;

        // Reset held with the line toggling.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rxd = i[0];
            tick_clk(1);
        end
        rxd = 1'b1;
        tick_clk(2);
        rst = 1'b1;
        idle(200);
        chk("idle_no_rda", 32'(rda_cnt), 32'd0);
        chk("idle_no_ferr", 32'(ferr_cnt), 32'd0);
        chk("idle_busy_low", {31'd0, rx_busy}, 32'd0);

        // Back-to-back 0x77 then 0x6A.
        r0 = rda_cnt;
        send_frame(8'h77, 1'b1, 1'b0, 1);
        chk("b2b_first_pending", {24'd0, rx_data}, 32'h77);
        send_frame(8'h6A, 1'b1, 1'b0, 1);
        idle(2 * BIT_CLK);
        chk("b2b_rda_count", 32'(rda_cnt - r0), 32'd2);
        chk("b2b_last_byte", {24'd0, rx_data}, 32'h6A);

        // Glitch of 16 clk is rejected.
        r0 = rda_cnt; f0 = ferr_cnt;
        glitch(16);
        idle(2 * BIT_CLK);
        chk("glitch_no_rda", 32'(rda_cnt - r0), 32'd0);
        chk("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("glitch_rx_data", {24'd0, rx_data}, 32'h6A);

        // Bad stop followed by a 20 bit-time break, then a good 0x57.
        r0 = rda_cnt; f0 = ferr_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 20);
        idle(2 * BIT_CLK);
        chk("break_one_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("break_no_rda", 32'(rda_cnt - r0), 32'd0);
        chk("break_rx_data", {24'd0, rx_data}, 32'h6A);
        send_frame(8'h57, 1'b1, 1'b0, 1);
        idle(BIT_CLK);
        chk("after_break_byte", {24'd0, rx_data}, 32'h57);

        // Reset asserted during bit 4 of 0x6A, then a clean 0x44.
        r0 = rda_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        d = 8'h6A;
        rxd = 1'b0;
        tick_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            tick_clk(BIT_CLK);
        end
        rxd = d[4];
        tick_clk(BIT_CLK / 2);
        rst = 1'b0;
        tick_clk(3);
        chk("midreset_rx_data", {24'd0, rx_data}, 32'h00);
        rxd = 1'b1;
        tick_clk(3);
        rst = 1'b1;
        idle(2 * BIT_CLK);
        send_frame(8'h44, 1'b1, 1'b0, 1);
        idle(2 * BIT_CLK);
        chk("midreset_one_rda", 32'(rda_cnt - r0), 32'd1);
        chk("midreset_no_err", 32'(ferr_cnt - f0 + perr_cnt - p0), 32'd0);
        chk("midreset_byte", {24'd0, rx_data}, 32'h44);

        if (PAR_EN) begin
            r0 = rda_cnt; p0 = perr_cnt;
            send_frame(8'h77, 1'b1, 1'b0, 1);
            idle(BIT_CLK);
            chk("par_good_rda", 32'(rda_cnt - r0), 32'd1);
            send_frame(8'h77, 1'b1, 1'b1, 1);
            idle(BIT_CLK);
            chk("par_bad_perr", 32'(perr_cnt - p0), 32'd1);
            chk("par_bad_no_rda", 32'(rda_cnt - r0), 32'd1);
        end

        // Randomized traffic: gaps, back-to-back frames, bad stops, parity flips and glitches.
        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            bad  = ($urandom_range(0, 5) == 0);
            flip = ($urandom_range(0, 4) == 0);
            send_frame(d, !bad, flip, int'($urandom_range(1, 3)));
            if (bad) begin
                idle(BIT_CLK * int'($urandom_range(1, 2)));
            end else begin
                idle(int'($urandom_range(0, 2)) * BIT_CLK + int'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 5) == 0) begin
                glitch(int'($urandom_range(4, 20)));
                idle(BIT_CLK + 8);
            end
        end

        // Drain outstanding expectations.
        for (int i = 0; i < 4 * BIT_CLK && exp_q.size() > 0; i++) begin
            tick_clk(1);
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- UART receive stage of the SPART, directly upstream of the SPART-to-CPU keyboard interface.
- Oversamples the serial line 16x, deframes 8N1 characters LSB-first and presents each good byte on rx_data with a one-cycle rda strobe.
- Downstream captures rx_data on the rda cycle; rx_data drives the interface's 8-bit databus.

Parameters:
- DIVISOR, 27, clk cycles per 16x oversample tick (50 MHz / (115200*16)); legal range 2..65535.
- CNT_W, 16, width of the tick divider counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- rxd  in  1  serial line, asynchronous to clk, idles high.
- rx_data  out  8  last correctly framed byte; held until the next good frame.
- rda  out  1  one-cycle pulse: new byte valid on rx_data this cycle.
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- rx_busy  out  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset (rst low, async): rx_data=8'h00, rda=0, framing_err=0, rx_busy=0, state=IDLE, divider=0, both synchroniser flops=1.
- rxd passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- Tick divider: counts 0..DIVISOR-1 continuously from reset; tick=1 for one clk when count==DIVISOR-1, then wraps to 0. Free-running, never re-phased.
- Oversample counter os_cnt (4 bit) advances on tick only; the mid-bit sample point is os_cnt==7.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on a tick with rxs==0, clear os_cnt and go to START.
- START: at os_cnt==7, if rxs==1 (glitch) return to IDLE with no outputs; otherwise clear os_cnt and go to DATA.
- DATA: every 16 ticks (os_cnt==15 -> 0) sample rxs into shift register bit[bit_idx], LSB first. After bit 7, go to STOP.
- STOP: sample at mid-bit.
  - rxs==1: load rx_data, pulse rda in the next clk, go to IDLE.
  - rxs==0: pulse framing_err, leave rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1 on a tick, then go to IDLE. A break condition therefore yields exactly one framing_err.
- Latency: rda asserts one clk after the tick on which the stop bit is sampled, i.e. roughly 9.5 bit times after the start-bit falling edge, plus 2 clk of synchroniser delay.
- rda and framing_err are mutually exclusive and each lasts exactly one clk.
- No receive buffer and no backpressure: a downstream miss loses that byte. Back-to-back frames (stop immediately followed by start) must all be received.
- Reset asserted mid-frame aborts immediately. After release, the block waits in IDLE for the next falling edge; a partial frame never produces rda.

Optional Feature:
- SPART_RX_PARITY_EN defined: frame is 8E1. One even-parity bit is sampled between bit 7 and the stop bit (extra PARITY state). Adds output parity_err (1 bit), a one-cycle pulse raised in the stop-bit cycle when the parity is wrong. On parity error rda is suppressed and rx_data is unchanged. If both parity and stop are bad, only framing_err pulses.
- Undefined: 8N1 only, no parity_err port, no PARITY state.

Test Plan:
- Reset: hold rst=0 with rxd toggling -> rx_data=00, rda=0, framing_err=0, rx_busy=0. Release, idle 200 clk -> no pulses.
- DIVISOR=4 (64 clk/bit): send 8N1 0x77 then 0x6A back-to-back -> exactly two rda pulses, rx_data=0x77 then 0x6A, rx_busy low between frames for at most 1 bit time.
- Glitch: rxd low for 16 clk (4 ticks) -> returns to IDLE, no rda, no framing_err, rx_data unchanged.
- Bad stop: send 0x11 with stop=0, hold rxd low 20 bit times -> exactly one framing_err pulse, no rda, rx_data keeps its prior value. A following good 0x57 -> rda, rx_data=0x57.
- Reset mid-frame: assert rst during bit 4 of 0x6A, release, then send 0x44 -> a single rda with 0x44 and no spurious pulse.
- SPART_RX_PARITY_EN: send 0x77 with parity=0 -> rda with 0x77. Send 0x77 with parity=1 -> parity_err pulse, no rda.
